cla_byte_serial_sequencer: RTL and testbench

Byte-serial multi-word adder controller for the 8-bit carry-lookahead adder stage. It accepts a WORDS-byte add request over a valid/ready handshake and drives the adder one byte per cycle, LSB first, with a registered carry chained between bytes. It collects the per-byte sums into a full-width result and presents it downstream with its own valid/ready handshake. It sits directly upstream of the adder (as its operand source) and downstream of it (as its result consumer).

---
 rtl/cla_byte_serial_sequencer.sv | 136 +++++++++++++
 tb/tb_cla_byte_serial_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cla_byte_serial_sequencer.sv
// cla_byte_serial_sequencer
//   Byte-serial multi-word add controller for an external 8-bit
//   carry-lookahead adder stage. A WORDS-byte request is latched on the
//   input handshake. The adder is then driven one byte per cycle, LSB
//   first, with the carry registered between bytes. The per-byte sums are
//   collected into a full-width result that is held on the output
//   handshake until it is taken.
//
// Parameters
//   WORDS      number of 8-bit slices per operand (2..16)
//
// Ports
//   clk, rst   clock; asynchronous active-high reset
//   in_*       request channel: valid/ready, operands a/b, carry-in
//   out_*      result channel: valid/ready, sum, carry-out, overflow
//   add_*      adder stage: operand bytes/carry out, sum/carry back
//
// Build option
//   CLA_SEQ_OVF_EN  when defined, adds the out_ovf port (signed overflow
//                   of the full-width add) and its logic.

module cla_byte_serial_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WORDS-1:0]   in_a,
  input  logic [8*WORDS-1:0]   in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORDS-1:0]   out_sum,
  output logic                 out_cout,
`ifdef CLA_SEQ_OVF_EN
  output logic                 out_ovf,
`endif
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_cin,
  input  logic [7:0]           add_sum,
  input  logic                 add_cout
);

  localparam int unsigned IDXW = $clog2(WORDS);
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state;
  logic [8*WORDS-1:0]    a_reg;
  logic [8*WORDS-1:0]    b_reg;
  logic                  carry;
  logic [IDXW-1:0]       idx;

  // Operand bytes are selected straight from the registers so the adder
  // sees them for the whole cycle and its sum is captured at the edge.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[{idx, 3'b000} +: 8];
      add_b   = b_reg[{idx, 3'b000} +: 8];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= in_b;
            carry    <= in_cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          out_sum[{idx, 3'b000} +: 8] <= add_sum;
          carry <= add_cout;
          if (idx == LAST) begin
            // idx parks on the last byte instead of wrapping; it is
            // cleared again when the next request is accepted.
            out_cout  <= add_cout;
`ifdef CLA_SEQ_OVF_EN
            out_ovf   <= (a_reg[8*WORDS-1] ~^ b_reg[8*WORDS-1]) &
                         (a_reg[8*WORDS-1] ^ add_sum[7]);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_byte_serial_sequencer.sv
// Testbench for cla_byte_serial_sequencer (WORDS = 4). The adder stage is
// modelled as a plain 8-bit add; expected results come from full-width
// arithmetic on the original operands.

module tb_cla_byte_serial_sequencer;

  localparam int unsigned W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [8*W-1:0]  in_a;
  logic [8*W-1:0]  in_b;
  logic            in_cin;
  logic            out_valid;
  logic            out_ready;
  logic [8*W-1:0]  out_sum;
  logic            out_cout;
`ifdef CLA_SEQ_OVF_EN
  logic            out_ovf;
`endif
  logic [7:0]      add_a;
  logic [7:0]      add_b;
  logic            add_cin;
  logic [7:0]      add_sum;
  logic            add_cout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External 8-bit adder stage.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  cla_byte_serial_sequencer #(.WORDS(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef CLA_SEQ_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Carry entering byte i of a + b + cin.
  function automatic logic carry_into(input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input int i);
    logic [32:0] mask;
    logic [32:0] lo;
    mask = (33'd1 << (8 * i)) - 33'd1;
    lo   = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, cin};
    return lo[8*i];
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] v, input int i);
    logic [31:0] s;
    s = v >> (8 * i);
    return s[7:0];
  endfunction

  function automatic logic ovf_of(input logic [31:0] a, input logic [31:0] b, input logic cin);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // One full request: handshake, per-byte adder drive, result, optional
  // backpressure stall of `stall` cycles with an ignored in_valid pulse.
  task automatic do_req(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input int stall);
    logic [32:0] exp;
    logic [31:0] held;
    exp = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));  // ignored outside DONE
      chk($sformatf("add_a_b%0d", i), add_a, byte_of(a, i));
      chk($sformatf("add_b_b%0d", i), add_b, byte_of(b, i));
      chk($sformatf("add_cin_b%0d", i), add_cin, carry_into(a, b, cin, i));
      chk("out_valid_run", out_valid, 0);
      chk("in_ready_run", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_latency", out_valid, 1);
    chk("out_sum", out_sum, exp[31:0]);
    chk("out_cout", out_cout, exp[32]);
`ifdef CLA_SEQ_OVF_EN
    chk("out_ovf", out_ovf, ovf_of(a, b, cin));
`endif
    chk("add_a_done", add_a, 0);
    chk("add_cin_done", add_cin, 0);
    held = out_sum;
    for (int s = 0; s < stall; s++) begin
      if (s == 0) begin
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", out_sum, held);
      chk("stall_cout", out_cout, exp[32]);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);
`ifdef CLA_SEQ_OVF_EN
    chk("rst_out_ovf", out_ovf, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_req(32'h12345678, 32'h11111111, 1'b0, 0);
    do_req(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    do_req(32'h000000FF, 32'h00000000, 1'b1, 0);
    do_req(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 3);
`ifdef CLA_SEQ_OVF_EN
    do_req(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
    do_req(32'h80000000, 32'h80000000, 1'b0, 1);
`endif

    // Reset two cycles into RUN discards the request.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'hCAFEBABE; in_b = 32'h01020304; in_cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_add_a", add_a, 8'hFE);
    rst = 1'b1;
    #1;
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_in_ready", in_ready, 1);
    chk("midrun_rst_add_a", add_a, 0);
    chk("midrun_rst_add_cin", add_cin, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    do_req(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      do_req(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
